// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the rx echo stream and a message source.
// Echo bytes are buffered because rx-ready pulses cannot be stalled.
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH   = 8,
    parameter int AW           = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rx_byte_rdy,
    input  logic [7:0]    i_rx_byte,
    input  logic          i_msg_valid,
    input  logic [7:0]    i_msg_byte,
    output logic          o_msg_ready,
    output logic          o_tx_byte_rdy,
    output logic [7:0]    o_tx_byte,
    input  logic          i_tx_busy,
    output logic          o_echo_overflow,
    output logic [AW:0]   o_fifo_count
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_ECHO = 1'b0,
        GRANT_MSG  = 1'b1
    } src_t;

    state_t        state_q, state_d;
    src_t          last_grant_q, last_grant_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          overflow_q, overflow_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic echo_pend;
    logic msg_pend;
    logic grant_echo;
    logic grant_msg;
    logic push;
    logic pop;

    assign echo_pend = (count_q != '0);
    assign msg_pend  = i_msg_valid;

    // Round-robin: on contention the source that did not win last time goes next.
    always_comb begin
        grant_echo = 1'b0;
        grant_msg  = 1'b0;
        if (state_q == IDLE && !i_tx_busy) begin
            if (echo_pend && msg_pend) begin
                if (last_grant_q == GRANT_MSG) begin
                    grant_echo = 1'b1;
                end else begin
                    grant_msg = 1'b1;
                end
            end else if (echo_pend) begin
                grant_echo = 1'b1;
            end else if (msg_pend) begin
                grant_msg = 1'b1;
            end
        end
    end

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    always_comb begin
        pop        = grant_echo;
        push       = i_rx_byte_rdy && ((count_q != DEPTH_C) || pop);
        overflow_d = overflow_q || (i_rx_byte_rdy && !push);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_rx_byte;
        end
    end

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        tx_byte_d    = tx_byte_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_echo) begin
                    tx_byte_d    = fifo_mem[rd_ptr_q];
                    last_grant_d = GRANT_ECHO;
                    state_d      = LAUNCH;
                end else if (grant_msg) begin
                    tx_byte_d    = i_msg_byte;
                    last_grant_d = GRANT_MSG;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never acknowledges must not hang the arbiter.
                if (i_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_MSG;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tx_byte_q    <= 8'h00;
            overflow_q   <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tx_byte_q    <= tx_byte_d;
            overflow_q   <= overflow_d;
            tmo_q        <= tmo_d;
        end
    end

    assign o_msg_ready     = grant_msg;
    assign o_tx_byte_rdy   = (state_q == LAUNCH);
    assign o_tx_byte       = tx_byte_q;
    assign o_echo_overflow = overflow_q;
    assign o_fifo_count    = count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model and launch monitor.
module tb_uart_tx_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_rx_byte_rdy = 1'b0;
    logic [7:0] i_rx_byte = 8'h00;
    logic       i_msg_valid = 1'b0;
    logic [7:0] i_msg_byte = 8'h00;
    logic       o_msg_ready;
    logic       o_tx_byte_rdy;
    logic [7:0] o_tx_byte;
    logic       i_tx_busy = 1'b0;
    logic       o_echo_overflow;
    logic [3:0] o_fifo_count;

    always #5 i_clk = ~i_clk;

    uart_tx_arbiter #(
        .FIFO_DEPTH  (8),
        .AW          (3),
        .BUSY_TIMEOUT(4)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rx_byte_rdy  (i_rx_byte_rdy),
        .i_rx_byte      (i_rx_byte),
        .i_msg_valid    (i_msg_valid),
        .i_msg_byte     (i_msg_byte),
        .o_msg_ready    (o_msg_ready),
        .o_tx_byte_rdy  (o_tx_byte_rdy),
        .o_tx_byte      (o_tx_byte),
        .i_tx_busy      (i_tx_busy),
        .o_echo_overflow(o_echo_overflow),
        .o_fifo_count   (o_fifo_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [7:0] launch_q[$];
    int         launch_cyc_q[$];
    int         msg_acc_cnt = 0;

    // busy_mode: 0 never busy, 1 busy 10 cycles starting 1 cycle after launch, 2 held busy
    int busy_mode = 1;
    int busy_left = 0;

    logic [7:0] msg_list [2];
    int msg_total = 0;
    int msg_idx = 0;
    int msg_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic push_rx(input logic [7:0] b);
        i_rx_byte     = b;
        i_rx_byte_rdy = 1'b1;
        tick();
        i_rx_byte_rdy = 1'b0;
    endtask

    task automatic start_msgs(input int n, input logic [7:0] b0, input logic [7:0] b1);
        msg_list[0] = b0;
        msg_list[1] = b1;
        msg_total   = n;
        msg_idx     = 0;
        msg_seen    = msg_acc_cnt;
        i_msg_byte  = b0;
        i_msg_valid = 1'b1;
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int b;
        b = 0;
        while (launch_q.size() < n && b < budget) begin
            tick();
            b++;
            if (i_msg_valid && msg_acc_cnt != msg_seen) begin
                msg_seen = msg_acc_cnt;
                msg_idx++;
                if (msg_idx < msg_total) i_msg_byte = msg_list[msg_idx];
                else i_msg_valid = 1'b0;
            end
        end
        check_eq(tag, 32'(launch_q.size() >= n), 32'd1);
    endtask

    function automatic logic [31:0] launch_at(input int i);
        if (i < launch_q.size()) return {24'd0, launch_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    // Launch and message-acceptance monitor, sampled mid-cycle.
    initial forever begin
        @(negedge i_clk);
        if (o_tx_byte_rdy === 1'b1) begin
            launch_q.push_back(o_tx_byte);
            launch_cyc_q.push_back(cyc);
            $display("launch byte %02h at cycle %0d", o_tx_byte, cyc);
        end
        if (o_msg_ready === 1'b1) msg_acc_cnt++;
    end

    // Transmitter model.
    initial begin
        logic lp;
        forever begin
            @(negedge i_clk);
            lp = (o_tx_byte_rdy === 1'b1);
            @(posedge i_clk);
            #1;
            if (busy_mode == 2) begin
                i_tx_busy = 1'b1;
            end else if (busy_mode == 1 && lp) begin
                i_tx_busy = 1'b1;
                busy_left = 10;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) i_tx_busy = 1'b0;
            end else begin
                i_tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int b;
        int base;

        // Reset state
        busy_mode = 1;
        tick();
        tick();
        i_rst_n = 1'b1;
        check_eq("rst_count", 32'(o_fifo_count), 32'd0);
        check_eq("rst_tx_byte", 32'(o_tx_byte), 32'h00);
        check_eq("rst_tx_rdy", 32'(o_tx_byte_rdy), 32'd0);
        check_eq("rst_ovf", 32'(o_echo_overflow), 32'd0);
        check_eq("rst_msg_ready", 32'(o_msg_ready), 32'd0);

        // Basic echo: launch 2 cycles after the pulse, FSM idle again when busy falls
        push_rx(8'hA5);
        check_eq("echo_count1", 32'(o_fifo_count), 32'd1);
        check_eq("echo_rdy_early", 32'(o_tx_byte_rdy), 32'd0);
        tick();
        check_eq("echo_rdy", 32'(o_tx_byte_rdy), 32'd1);
        check_eq("echo_byte", 32'(o_tx_byte), 32'hA5);
        check_eq("echo_count0", 32'(o_fifo_count), 32'd0);
        c0 = cyc;
        i_msg_valid = 1'b1;
        i_msg_byte  = 8'h5A;
        tick();
        check_eq("echo_rdy_single", 32'(o_tx_byte_rdy), 32'd0);
        b = 0;
        while (!o_msg_ready && b < 40) begin
            tick();
            b++;
        end
        check_eq("echo_idle_delay", 32'(cyc - c0), 32'd12);
        tick();
        i_msg_valid = 1'b0;
        check_eq("msg_launch_rdy", 32'(o_tx_byte_rdy), 32'd1);
        check_eq("msg_launch_byte", 32'(o_tx_byte), 32'h5A);
        repeat (16) tick();

        // Contention: echo and message alternate, echo first
        busy_mode = 2;
        tick();
        push_rx(8'h11);
        push_rx(8'h22);
        check_eq("cont_count", 32'(o_fifo_count), 32'd2);
        start_msgs(2, 8'hC0, 8'hC1);
        check_eq("cont_ready_busy", 32'(o_msg_ready), 32'd0);
        base = msg_acc_cnt;
        launch_q.delete();
        busy_mode = 1;
        run_until("cont_wait", 4, 200);
        repeat (16) tick();
        check_eq("cont_l0", launch_at(0), 32'h11);
        check_eq("cont_l1", launch_at(1), 32'hC0);
        check_eq("cont_l2", launch_at(2), 32'h22);
        check_eq("cont_l3", launch_at(3), 32'hC1);
        check_eq("cont_ready_cnt", 32'(msg_acc_cnt - base), 32'd2);

        // Overflow: ninth byte dropped and flag sticks
        busy_mode = 2;
        tick();
        for (int i = 1; i <= 8; i++) push_rx(8'(i));
        check_eq("ovf_count8", 32'(o_fifo_count), 32'd8);
        check_eq("ovf_flag_pre", 32'(o_echo_overflow), 32'd0);
        push_rx(8'h09);
        check_eq("ovf_count9", 32'(o_fifo_count), 32'd8);
        check_eq("ovf_flag", 32'(o_echo_overflow), 32'd1);
        launch_q.delete();
        busy_mode = 1;
        run_until("ovf_wait", 8, 400);
        repeat (20) tick();
        check_eq("ovf_nlaunch", 32'(launch_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check_eq("ovf_order", launch_at(i), 32'(i + 1));
        check_eq("ovf_sticky", 32'(o_echo_overflow), 32'd1);

        // Full FIFO with push and pop on the same edge
        busy_mode = 2;
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        check_eq("rst_ovf_clear", 32'(o_echo_overflow), 32'd0);
        for (int i = 0; i < 8; i++) push_rx(8'hA0 + 8'(i));
        check_eq("full_count", 32'(o_fifo_count), 32'd8);
        launch_q.delete();
        busy_mode = 0;
        b = 0;
        while (i_tx_busy && b < 5) begin
            tick();
            b++;
        end
        check_eq("full_busy_low", 32'(i_tx_busy), 32'd0);
        push_rx(8'hAF);
        check_eq("full_pp_count", 32'(o_fifo_count), 32'd8);
        check_eq("full_pp_ovf", 32'(o_echo_overflow), 32'd0);
        run_until("full_wait", 9, 200);
        repeat (10) tick();
        check_eq("full_nlaunch", 32'(launch_q.size()), 32'd9);
        for (int i = 0; i < 8; i++) check_eq("full_order", launch_at(i), 32'hA0 + 32'(i));
        check_eq("full_last", launch_at(8), 32'hAF);

        // Busy timeout: transmitter never acknowledges
        launch_q.delete();
        launch_cyc_q.delete();
        push_rx(8'h3C);
        push_rx(8'h3D);
        run_until("tmo_wait", 2, 60);
        repeat (12) tick();
        check_eq("tmo_nlaunch", 32'(launch_q.size()), 32'd2);
        check_eq("tmo_first", launch_at(0), 32'h3C);
        check_eq("tmo_second", launch_at(1), 32'h3D);
        if (launch_cyc_q.size() >= 2)
            check_eq("tmo_spacing", 32'(launch_cyc_q[1] - launch_cyc_q[0]), 32'd6);
        else
            check_eq("tmo_spacing", 32'(launch_cyc_q.size()), 32'd2);

        // Reset mid-operation with bytes queued and transfer in progress
        busy_mode = 1;
        push_rx(8'h51);
        push_rx(8'h52);
        push_rx(8'h53);
        push_rx(8'h54);
        check_eq("midrst_count_pre", 32'(o_fifo_count), 32'd3);
        check_eq("midrst_byte_pre", 32'(o_tx_byte), 32'h51);
        busy_mode = 2;
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        check_eq("midrst_count", 32'(o_fifo_count), 32'd0);
        check_eq("midrst_byte", 32'(o_tx_byte), 32'h00);
        check_eq("midrst_ovf", 32'(o_echo_overflow), 32'd0);
        check_eq("midrst_rdy", 32'(o_tx_byte_rdy), 32'd0);
        launch_q.delete();
        repeat (20) tick();
        check_eq("midrst_no_launch", 32'(launch_q.size()), 32'd0);
        push_rx(8'hE1);
        start_msgs(1, 8'h77, 8'h00);
        tick();
        check_eq("midrst_ready_busy", 32'(o_msg_ready), 32'd0);
        busy_mode = 1;
        run_until("midrst_wait", 2, 100);
        check_eq("midrst_first", launch_at(0), 32'hE1);
        check_eq("midrst_second", launch_at(1), 32'h77);

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
